// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer
// Per-channel PWM sequencer for the RGBnPWM inputs of the LED driver macro.
// Each channel runs one of OFF / ON / PWM / BLINK / BREATHE. New settings are
// written into a shadow register and copied to the active set only when the
// PWM counter wraps, so a period that is already running is never disturbed.
//
// Breathe ramp direction:
//   state    | meaning
//   DIR_UP   | ramp climbs one step per period towards duty
//   DIR_DOWN | ramp falls one step per period towards zero

module rgb_pwm_sequencer #(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_LOG2 = 8,
  parameter int BLINK_LOG2    = 5,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clki,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [2:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam int PS_W = (PRESCALE_LOG2 > 0) ? PRESCALE_LOG2 : 1;
  localparam int BL_W = (BLINK_LOG2 > 0) ? BLINK_LOG2 : 1;

  // With a zero log2 the counter collapses to one bit that stays at 0, so
  // the terminal-count compare fires every cycle / every boundary.
  localparam logic [PS_W-1:0]     PS_MAX  = PS_W'((64'd1 << PRESCALE_LOG2) - 64'd1);
  localparam logic [BL_W-1:0]     BL_MAX  = BL_W'((64'd1 << BLINK_LOG2) - 64'd1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  // Mode codes; 5..7 are treated as OFF.
  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_ON      = 3'd1;
  localparam logic [2:0] MODE_PWM     = 3'd2;
  localparam logic [2:0] MODE_BLINK   = 3'd3;
  localparam logic [2:0] MODE_BREATHE = 3'd4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Timebase
  logic [PS_W-1:0]     ps;
  logic                tick;
  logic [PWM_BITS-1:0] cnt;
  logic                boundary;

  // Per-channel configuration and sequencing state
  logic [2:0]          shd_mode [CHANNELS];
  logic [PWM_BITS-1:0] shd_duty [CHANNELS];
  logic [2:0]          act_mode [CHANNELS];
  logic [PWM_BITS-1:0] act_duty [CHANNELS];
  logic [PWM_BITS-1:0] ramp     [CHANNELS];
  dir_e                dir      [CHANNELS];
  logic [BL_W-1:0]     bcnt     [CHANNELS];
  logic [CHANNELS-1:0] phase;

  // Next-state helpers
  logic [CHANNELS-1:0] wr_sel;
  logic [CHANNELS-1:0] mode_chg;
  logic [CHANNELS-1:0] bl_wrap;
  logic [2:0]          nxt_mode [CHANNELS];
  logic [PWM_BITS-1:0] nxt_duty [CHANNELS];
  logic [PWM_BITS-1:0] ramp_nxt [CHANNELS];
  dir_e                dir_nxt  [CHANNELS];
  logic [PWM_BITS-1:0] lvl      [CHANNELS];

  assign tick     = (ps == PS_MAX);
  assign boundary = tick && (cnt == CNT_MAX);

  // Prescaler: free-running divider that produces one tick per terminal count.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      ps <= '0;
    end else begin
      ps <= tick ? '0 : ps + 1'b1;
    end
  end

  // PWM period counter plus the period_start pulse one cycle after the wrap.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= cnt + 1'b1;
      end
      period_start <= boundary;
    end
  end

  // Write decode and the value each channel would adopt at the next boundary.
  // A write landing on the boundary cycle bypasses the shadow directly.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      wr_sel[n]   = cfg_we && (32'(cfg_ch) == 32'(n));
      nxt_mode[n] = wr_sel[n] ? cfg_mode : shd_mode[n];
      nxt_duty[n] = wr_sel[n] ? cfg_duty : shd_duty[n];
      mode_chg[n] = (nxt_mode[n] != act_mode[n]);
      bl_wrap[n]  = (bcnt[n] == BL_MAX);
    end
  end

  // Breathe triangle step, evaluated against the duty that becomes active.
  // The turn-around step moves immediately so each peak/valley lasts one period.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      ramp_nxt[n] = ramp[n];
      dir_nxt[n]  = dir[n];
      if (nxt_duty[n] == '0) begin
        ramp_nxt[n] = '0;
        dir_nxt[n]  = DIR_UP;
      end else if (ramp[n] > nxt_duty[n]) begin
        ramp_nxt[n] = ramp[n] - 1'b1;
        dir_nxt[n]  = DIR_DOWN;
      end else if (dir[n] == DIR_UP) begin
        if (ramp[n] == nxt_duty[n]) begin
          ramp_nxt[n] = ramp[n] - 1'b1;
          dir_nxt[n]  = DIR_DOWN;
        end else begin
          ramp_nxt[n] = ramp[n] + 1'b1;
        end
      end else begin
        if (ramp[n] == '0) begin
          ramp_nxt[n] = ramp[n] + 1'b1;
          dir_nxt[n]  = DIR_UP;
        end else begin
          ramp_nxt[n] = ramp[n] - 1'b1;
        end
      end
    end
  end

  // Shadow capture, boundary transfer to active, and ramp/blink sequencing.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < CHANNELS; n++) begin
        shd_mode[n] <= MODE_OFF;
        shd_duty[n] <= '0;
        act_mode[n] <= MODE_OFF;
        act_duty[n] <= '0;
        ramp[n]     <= '0;
        dir[n]      <= DIR_UP;
        bcnt[n]     <= '0;
      end
      phase <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (wr_sel[n]) begin
          shd_mode[n] <= cfg_mode;
          shd_duty[n] <= cfg_duty;
        end
        if (boundary) begin
          act_mode[n] <= nxt_mode[n];
          act_duty[n] <= nxt_duty[n];
          if (mode_chg[n]) begin
            ramp[n]  <= '0;
            dir[n]   <= DIR_UP;
            bcnt[n]  <= '0;
            phase[n] <= 1'b0;
          end else begin
            if (act_mode[n] == MODE_BLINK) begin
              bcnt[n] <= bl_wrap[n] ? '0 : bcnt[n] + 1'b1;
              if (bl_wrap[n]) begin
                phase[n] <= ~phase[n];
              end
            end
            if (act_mode[n] == MODE_BREATHE) begin
              ramp[n] <= ramp_nxt[n];
              dir[n]  <= dir_nxt[n];
            end
          end
        end
      end
    end
  end

  // Compare level selected by the active mode.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      case (act_mode[n])
        MODE_PWM:     lvl[n] = act_duty[n];
        MODE_BLINK:   lvl[n] = phase[n] ? act_duty[n] : '0;
        MODE_BREATHE: lvl[n] = ramp[n];
        default:      lvl[n] = '0;
      endcase
    end
  end

  // Registered PWM outputs; ON bypasses the compare to stay solidly high.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        pwm_out[n] <= (act_mode[n] == MODE_ON) || (cnt < lvl[n]);
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer with a 16-tick period and no prescale.
// Each run_period call measures one full PWM period on every channel and can
// inject up to two config writes at chosen cycles within that period.

module tb_rgb_pwm_sequencer;

  logic       clki;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [2:0] cfg_mode;
  logic [3:0] cfg_duty;
  logic [2:0] pwm_out;
  logic       period_start;

  int vectors     = 0;
  int miscompares = 0;
  int pnum        = 1;

  typedef struct packed {
    logic [4:0] at;
    logic [1:0] ch;
    logic [2:0] mode;
    logic [3:0] duty;
  } wr_t;

  localparam wr_t NW = {5'd31, 2'd0, 3'd0, 4'd0};

  rgb_pwm_sequencer #(
    .CHANNELS      (3),
    .PWM_BITS      (4),
    .PRESCALE_LOG2 (0),
    .BLINK_LOG2    (1)
  ) dut (
    .clki         (clki),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_duty     (cfg_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  initial begin
    clki = 1'b0;
    forever #5 clki = ~clki;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic wr_t wr(input int at, input int ch, input int mode, input int duty);
    wr_t w;
    w.at   = 5'(at);
    w.ch   = 2'(ch);
    w.mode = 3'(mode);
    w.duty = 4'(duty);
    return w;
  endfunction

  task automatic drive(input wr_t w);
    cfg_we   = 1'b1;
    cfg_ch   = w.ch;
    cfg_mode = w.mode;
    cfg_duty = w.duty;
  endtask

  // Count negedges from release until the first period_start (bounded).
  task automatic wait_first_ps(input string tag);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (n < 40 && !found) begin
      @(negedge clki);
      n++;
      if (period_start) found = 1'b1;
    end
    chk(tag, n, 16);
  endtask

  // Called at the negedge where period_start is high; the next 16 samples are
  // the compare results for cnt 0..15 of the period that just started.
  task automatic run_period(input wr_t a, input wr_t b, input int e0, input int e1, input int e2);
    int hi [3];
    for (int c = 0; c < 3; c++) hi[c] = 0;
    for (int i = 0; i < 16; i++) begin
      if (int'(a.at) == i) drive(a);
      else if (int'(b.at) == i) drive(b);
      @(negedge clki);
      cfg_we = 1'b0;
      for (int c = 0; c < 3; c++) if (pwm_out[c]) hi[c]++;
    end
    chk($sformatf("p%0d_ch0", pnum), hi[0], e0);
    chk($sformatf("p%0d_ch1", pnum), hi[1], e1);
    chk($sformatf("p%0d_ch2", pnum), hi[2], e2);
    chk($sformatf("p%0d_wrap", pnum), int'(period_start), 1);
    pnum++;
  endtask

  initial begin
    rst      = 1'b1;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_mode = '0;
    cfg_duty = '0;
    repeat (3) @(negedge clki);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ps", int'(period_start), 0);
    rst = 1'b0;
    wait_first_ps("first_ps");

    // PWM duty sweep on ch0
    run_period(wr(0, 0, 2, 5),  NW, 0, 0, 0);    // P1
    run_period(NW,              NW, 5, 0, 0);    // P2
    run_period(wr(0, 0, 2, 0),  NW, 5, 0, 0);    // P3
    run_period(wr(0, 0, 2, 15), NW, 0, 0, 0);    // P4
    // ON, illegal mode, out-of-range channel
    run_period(wr(0, 1, 1, 0),  NW, 15, 0, 0);   // P5
    run_period(wr(0, 1, 6, 9),  NW, 15, 16, 0);  // P6
    run_period(wr(0, 3, 1, 15), NW, 15, 0, 0);   // P7
    // Shadow: last write wins, current period untouched
    run_period(wr(2, 0, 2, 3), wr(8, 0, 2, 9), 15, 0, 0);  // P8
    // Write on the boundary cycle takes effect in the starting period
    run_period(wr(15, 0, 2, 7), NW, 9, 0, 0);    // P9
    // BLINK on ch2
    run_period(wr(0, 2, 3, 8),  NW, 7, 0, 0);    // P10
    run_period(NW,              NW, 7, 0, 0);    // P11
    run_period(NW,              NW, 7, 0, 0);    // P12
    run_period(NW,              NW, 7, 0, 8);    // P13
    run_period(NW,              NW, 7, 0, 8);    // P14
    // BREATHE on ch0, duty 3
    run_period(wr(0, 0, 4, 3),  NW, 7, 0, 0);    // P15
    run_period(NW,              NW, 0, 0, 0);    // P16
    run_period(NW,              NW, 1, 0, 8);    // P17
    run_period(NW,              NW, 2, 0, 8);    // P18
    run_period(NW,              NW, 3, 0, 0);    // P19
    run_period(NW,              NW, 2, 0, 0);    // P20
    run_period(NW,              NW, 1, 0, 8);    // P21
    run_period(NW,              NW, 0, 0, 8);    // P22
    run_period(NW,              NW, 1, 0, 0);    // P23
    run_period(NW,              NW, 2, 0, 0);    // P24
    // Lower duty to 1 while ramp is at 3
    run_period(wr(0, 0, 4, 1),  NW, 3, 0, 8);    // P25
    run_period(NW,              NW, 2, 0, 8);    // P26
    run_period(NW,              NW, 1, 0, 0);    // P27
    run_period(NW,              NW, 0, 0, 0);    // P28
    run_period(NW,              NW, 1, 0, 8);    // P29
    run_period(wr(0, 1, 1, 0),  NW, 0, 0, 8);    // P30
    run_period(NW,              NW, 1, 16, 0);   // P31

    // Mid-run asynchronous reset
    chk("pre_rst_pwm1", int'(pwm_out[1]), 1);
    chk("pre_rst_ps", int'(period_start), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_ps", int'(period_start), 0);
    @(negedge clki);
    @(negedge clki);
    rst = 1'b0;
    wait_first_ps("rerun_first_ps");
    run_period(NW, NW, 0, 0, 0);
    run_period(NW, NW, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
